sa_tile_sequencer: RTL and testbench
====================================

Name: sa_tile_sequencer

Overview:
- Controller that runs one matrix-tile pass on the HPE x VPE systolic array: clears the accumulators, streams k_len operand vectors from the A/B operand RAMs, flushes the skew with zero operands, then strobes the result capture.
- Sits between the host/command logic and the array's AA/BB/Y datapath.
- Drives the operand-RAM read addresses plus the array's clear, enable and zero-fill controls.

Parameters:
- HPE, 8, horizontal PE count.
- VPE, 8, vertical PE count.
- AW, 14, operand RAM address / k_len width (RAM depth 10000 fits).
- FLUSH_CYC, HPE+VPE-1, zero-operand cycles needed to drain the skew.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- k_len  in  AW  number of operand vectors; latched on accepted start.
- base_a  in  AW  A RAM start address; latched on accepted start.
- base_b  in  AW  B RAM start address; latched on accepted start.
- a_rd  out  1  A RAM read enable; RAM read latency is 1 cycle.
- b_rd  out  1  B RAM read enable.
- a_addr  out  AW  A RAM read address.
- b_addr  out  AW  B RAM read address.
- sa_clr  out  1  clear array accumulators.
- sa_en  out  1  array advance enable.
- zero_fill  out  1  array operand mux selects 0 instead of RAM data.
- y_valid  out  1  Y bus holds final tile result; capture this cycle.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pass-complete pulse.
- err  out  1  one-cycle pulse on start with k_len==0.

Behaviour:
- All outputs are registered. Reset value of every output and internal counter is 0; state resets to IDLE.
- States: IDLE, CLEAR, FEED, FLUSH, OUT, DONE.
- IDLE:
  - start && k_len!=0: latch k_len, base_a and base_b; go to CLEAR.
  - start && k_len==0: err=1 for one cycle; stay in IDLE.
  - start outside IDLE is ignored.
- CLEAR: exactly one cycle with sa_clr=1; go to FEED with cnt=0.
- FEED:
  - a_rd=b_rd=1, a_addr=base_a+cnt, b_addr=base_b+cnt. Addition is modulo 2^AW (wraps, no error).
  - cnt increments each cycle; after the cycle with cnt==k_len-1, go to FLUSH with cnt=0.
- FLUSH: a_rd=b_rd=0 for FLUSH_CYC cycles; go to OUT.
- Issue pipeline:
  - issue = (state==FEED || state==FLUSH).
  - sa_en = issue delayed 1 cycle; zero_fill = (state==FLUSH) delayed 1 cycle.
  - This aligns sa_en with the 1-cycle RAM data latency.
- OUT: one cycle, covering the last delayed sa_en; go to DONE.
- DONE: y_valid=1 and done=1 for one cycle; go to IDLE.
- busy=1 in every state except IDLE. Both busy and done are high in the DONE cycle.
- Latency: with start accepted at edge 0, the cycle sequence is:
  - CLEAR in cycle 1.
  - FEED in cycles 2..k_len+1.
  - sa_en high in cycles 3..k_len+FLUSH_CYC+2.
  - done/y_valid in cycle k_len+FLUSH_CYC+3.
- abort, in any non-IDLE state:
  - Next cycle: state IDLE; a_rd, b_rd, sa_en, zero_fill and busy all 0.
  - No done and no y_valid.
  - abort in IDLE has no effect.
  - If abort and start are both asserted in IDLE, start wins.
- RST mid-pass: all outputs return to 0 immediately (asynchronously); no done follows.
- k_len==2^AW-1 is legal; the cnt compare must not overflow.

Test Plan:
- Reset: RST=1 mid-FEED -> all outputs 0 in the same cycle; after release, IDLE and busy=0.
- Nominal pass (HPE=VPE=8, k_len=4, base_a=0x10, base_b=0x20, start at edge 0) -> expect all of:
  - sa_clr in cycle 1.
  - a_addr 0x10..0x13 and b_addr 0x20..0x23 in cycles 2-5.
  - sa_en in cycles 3-21; zero_fill in cycles 7-21.
  - done=y_valid=1 in cycle 22 only.
- Zero length: start with k_len=0 -> err pulse for 1 cycle; busy stays 0; no RAM reads.
- Wrap: base_a=0x3FFE, k_len=3 -> a_addr sequence 0x3FFE, 0x3FFF, 0x0000.
- Abort: abort in the 2nd FEED cycle -> busy=0 next cycle; no done; a new start is accepted one cycle later.
- Start while busy: extra start pulses during FEED/FLUSH are ignored; done timing and count are unchanged (single done pulse).

Source files
------------

// File: rtl/sa_tile_sequencer.sv
// Tile-pass sequencer for an HPE x VPE systolic array: clear, stream k_len
// operand vectors from the A/B RAMs, drain the skew with zero operands, capture Y.
module sa_tile_sequencer #(
  parameter int HPE       = 8,
  parameter int VPE       = 8,
  parameter int AW        = 14,
  parameter int FLUSH_CYC = HPE + VPE - 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] k_len,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  output logic          a_rd,
  output logic          b_rd,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          sa_clr,
  output logic          sa_en,
  output logic          zero_fill,
  output logic          y_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    OUT,
    DONE
  } state_t;

  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [AW-1:0] FLUSH_LAST = AW'(FLUSH_CYC - 1);

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [AW-1:0] klen_q, base_a_q, base_b_q;
  logic          accept;

  logic          a_rd_d, b_rd_d, sa_clr_d, sa_en_d, zero_fill_d;
  logic          y_valid_d, busy_d, done_d, err_d;
  logic [AW-1:0] a_addr_d, b_addr_d;

  assign accept = (state == IDLE) && start && (k_len != '0);

  // State, counter and latched pass parameters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      klen_q   <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        klen_q   <= k_len;
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
    end
  end

  // Next state; klen_q is never 0 once latched, so klen_q-1 cannot underflow
  // and cnt never needs to reach 2^AW.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE:  if (accept) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt == klen_q - ONE) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      OUT:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are registered, so decode the state being entered; sa_en and
  // zero_fill instead decode the current state to lag issue by one cycle.
  always_comb begin
    a_rd_d      = (state_d == FEED);
    b_rd_d      = (state_d == FEED);
    a_addr_d    = (state_d == FEED) ? base_a_q + cnt_d : '0;
    b_addr_d    = (state_d == FEED) ? base_b_q + cnt_d : '0;
    sa_clr_d    = (state_d == CLEAR);
    sa_en_d     = ((state == FEED) || (state == FLUSH)) && !abort;
    zero_fill_d = (state == FLUSH) && !abort;
    y_valid_d   = (state_d == DONE);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    err_d       = (state == IDLE) && start && (k_len == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_rd      <= 1'b0;
      b_rd      <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      sa_clr    <= 1'b0;
      sa_en     <= 1'b0;
      zero_fill <= 1'b0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_rd      <= a_rd_d;
      b_rd      <= b_rd_d;
      a_addr    <= a_addr_d;
      b_addr    <= b_addr_d;
      sa_clr    <= sa_clr_d;
      sa_en     <= sa_en_d;
      zero_fill <= zero_fill_d;
      y_valid   <= y_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Directed bench for sa_tile_sequencer: nominal pass, wrap, zero length,
// abort, stray starts and asynchronous reset, checked cycle by cycle.
module tb_sa_tile_sequencer;

  localparam int AW = 14;
  localparam int F  = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start, abort;
  logic [AW-1:0] k_len, base_a, base_b;
  logic          a_rd, b_rd, sa_clr, sa_en, zero_fill, y_valid, busy, done, err;
  logic [AW-1:0] a_addr, b_addr;

  int n_vec = 0;
  int n_err = 0;

  sa_tile_sequencer #(.HPE(8), .VPE(8), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .k_len(k_len), .base_a(base_a), .base_b(base_b),
    .a_rd(a_rd), .b_rd(b_rd), .a_addr(a_addr), .b_addr(b_addr),
    .sa_clr(sa_clr), .sa_en(sa_en), .zero_fill(zero_fill),
    .y_valid(y_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // {sa_clr, a_rd, b_rd, sa_en, zero_fill, y_valid, done, busy, err}
  function automatic logic [8:0] ctl();
    return {sa_clr, a_rd, b_rd, sa_en, zero_fill, y_valid, done, busy, err};
  endfunction

  // Expected control vector c cycles after the accepting edge
  function automatic logic [8:0] exp_ctl(int c, int k);
    logic rd, en, zf, dn, bz;
    rd = (c >= 2) && (c <= k + 1);
    en = (c >= 3) && (c <= k + F + 2);
    zf = (c >= k + 3) && (c <= k + F + 2);
    dn = (c == k + F + 3);
    bz = (c >= 1) && (c <= k + F + 3);
    return {(c == 1), rd, rd, en, zf, dn, dn, bz, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Call at a negedge; start is sampled at the following edge (edge 0)
  task automatic run_pass(input int k, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                          input bit stray);
    logic [AW-1:0] ea, eb;
    start = 1'b1; k_len = AW'(k); base_a = ba; base_b = bb;
    for (int c = 1; c <= k + F + 5; c++) begin
      @(negedge CLK);
      start = stray && ((c == 3) || (c == k + 6));
      check($sformatf("ctl c%0d", c), 32'(ctl()), 32'(exp_ctl(c, k)));
      if ((c >= 2) && (c <= k + 1)) begin
        ea = ba + AW'(c - 2);
        eb = bb + AW'(c - 2);
        check($sformatf("a_addr c%0d", c), 32'(a_addr), 32'(ea));
        check($sformatf("b_addr c%0d", c), 32'(b_addr), 32'(eb));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    k_len = '0; base_a = '0; base_b = '0;
    repeat (2) @(negedge CLK);
    check("reset ctl", 32'(ctl()), 32'd0);
    check("reset addr", 32'({a_addr, b_addr}), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Nominal k=4: sa_en 3..21, zero_fill 7..21, done 22
    run_pass(4, 14'h0010, 14'h0020, 1'b0);

    // Hand-picked wrap addresses
    start = 1'b1; k_len = 14'd3; base_a = 14'h3FFE; base_b = 14'h0005;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); check("wrap a0", 32'(a_addr), 32'h3FFE);
    @(negedge CLK); check("wrap a1", 32'(a_addr), 32'h3FFF);
    @(negedge CLK); check("wrap a2", 32'(a_addr), 32'h0000);
    check("wrap b2", 32'(b_addr), 32'h0007);
    repeat (F + 4) @(negedge CLK);
    check("wrap idle", 32'(ctl()), 32'd0);

    // Zero length: one err pulse, nothing else
    start = 1'b1; k_len = '0;
    @(negedge CLK); start = 1'b0;
    check("zero err", 32'(ctl()), 32'h001);
    @(negedge CLK);
    check("zero after", 32'(ctl()), 32'h000);

    // Stray starts during FEED and FLUSH are ignored
    run_pass(5, 14'h0100, 14'h0200, 1'b1);

    // Abort in the second FEED cycle, restart the following cycle
    start = 1'b1; k_len = 14'd8; base_a = 14'h0300; base_b = 14'h0400;
    @(negedge CLK); start = 1'b0;
    check("abort clr", 32'(ctl()), 32'h102);
    @(negedge CLK);
    @(negedge CLK);
    check("abort feed2 addr", 32'(a_addr), 32'h0301);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    check("abort idle", 32'(ctl()), 32'd0);
    run_pass(2, 14'h0040, 14'h0050, 1'b0);

    // Asynchronous reset mid-FEED
    start = 1'b1; k_len = 14'd6; base_a = 14'h0011; base_b = 14'h0022;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("pre-rst feed", 32'(ctl()), 32'(exp_ctl(3, 6)));
    #2 RST = 1'b1;
    #1 check("rst async ctl", 32'(ctl()), 32'd0);
    check("rst async addr", 32'({a_addr, b_addr}), 32'd0);
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      check("post-rst idle", 32'(ctl()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
